// File: rtl/rom_fetch_arbiter.sv
// Round-robin arbiter sharing one single-ported instruction ROM between the IF and LS ports.
// Optional feature macro ROM_ALIGN_CHK_EN: misaligned requests end in a one-cycle ERR state instead of a ROM access.
module rom_fetch_arbiter #(
  parameter int WAIT_STATES = 0,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ifReq_i,
  input  logic [ADDR_W-1:0] ifAddr_i,
  output logic              ifAck_o,
  output logic [DATA_W-1:0] ifData_o,
  output logic              ifValid_o,
  output logic              ifErr_o,
  input  logic              lsReq_i,
  input  logic [ADDR_W-1:0] lsAddr_i,
  output logic              lsAck_o,
  output logic [DATA_W-1:0] lsData_o,
  output logic              lsValid_o,
  output logic              lsErr_o,
  output logic              romReq_o,
  output logic [ADDR_W-1:0] romAddr_o,
  input  logic [DATA_W-1:0] romInst_i,
  input  logic              romOk_i
);

  localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_STATES);

`ifdef ROM_ALIGN_CHK_EN
  typedef enum logic [1:0] {IDLE, ACCESS, ERR} state_t;
`else
  typedef enum logic [1:0] {IDLE, ACCESS} state_t;
`endif

  state_t            r_state;
  state_t            w_nextState;
  logic              r_rrPtr;
  logic              r_owner;
  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  r_count;
  logic              r_ifAck;
  logic              r_lsAck;
  logic              r_ifValid;
  logic              r_lsValid;
  logic [DATA_W-1:0] r_ifData;
  logic [DATA_W-1:0] r_lsData;

  logic              w_grant;
  logic              w_grantLs;
  logic [ADDR_W-1:0] w_grantAddr;
  logic              w_complete;
  logic [DATA_W-1:0] w_cplData;
`ifdef ROM_ALIGN_CHK_EN
  logic              w_errDone;
  logic              r_ifErr;
  logic              r_lsErr;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // r_rrPtr=1 means LS wins the next tie; it flips to the non-owner on every completion.
  always_comb begin
    w_nextState = r_state;
    w_grant     = 1'b0;
    w_grantLs   = 1'b0;
    w_grantAddr = ifAddr_i;
    w_complete  = 1'b0;
    w_cplData   = romInst_i;
`ifdef ROM_ALIGN_CHK_EN
    w_errDone   = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (ifReq_i || lsReq_i) begin
          w_grant     = 1'b1;
          w_grantLs   = lsReq_i && (!ifReq_i || r_rrPtr);
          w_grantAddr = w_grantLs ? lsAddr_i : ifAddr_i;
`ifdef ROM_ALIGN_CHK_EN
          w_nextState = (w_grantAddr[1:0] != 2'b00) ? ERR : ACCESS;
`else
          w_nextState = ACCESS;
`endif
        end
      end
      ACCESS: begin
        if ((r_count == '0) && romOk_i) begin
          w_complete  = 1'b1;
          w_nextState = IDLE;
        end
      end
`ifdef ROM_ALIGN_CHK_EN
      ERR: begin
        w_complete  = 1'b1;
        w_errDone   = 1'b1;
        w_cplData   = '0;
        w_nextState = IDLE;
      end
`endif
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rrPtr   <= 1'b0;
      r_owner   <= 1'b0;
      r_addr    <= '0;
      r_count   <= '0;
      r_ifAck   <= 1'b0;
      r_lsAck   <= 1'b0;
      r_ifValid <= 1'b0;
      r_lsValid <= 1'b0;
      r_ifData  <= '0;
      r_lsData  <= '0;
    end else begin
      r_ifAck   <= w_grant && !w_grantLs;
      r_lsAck   <= w_grant && w_grantLs;
      r_ifValid <= 1'b0;
      r_lsValid <= 1'b0;
      if (w_grant) begin
        r_addr  <= w_grantAddr;
        r_owner <= w_grantLs;
        r_count <= CNT_INIT;
      end else if ((r_state == ACCESS) && (r_count != '0)) begin
        r_count <= r_count - CNT_W'(1);
      end
      if (w_complete) begin
        r_rrPtr <= ~r_owner;
        if (r_owner) begin
          r_lsValid <= 1'b1;
          r_lsData  <= w_cplData;
        end else begin
          r_ifValid <= 1'b1;
          r_ifData  <= w_cplData;
        end
      end
    end
  end

`ifdef ROM_ALIGN_CHK_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ifErr <= 1'b0;
      r_lsErr <= 1'b0;
    end else if (w_complete) begin
      if (r_owner) begin
        r_lsErr <= w_errDone;
      end else begin
        r_ifErr <= w_errDone;
      end
    end
  end

  assign ifErr_o = r_ifErr;
  assign lsErr_o = r_lsErr;
`else
  assign ifErr_o = 1'b0;
  assign lsErr_o = 1'b0;
`endif

  assign ifAck_o   = r_ifAck;
  assign lsAck_o   = r_lsAck;
  assign ifValid_o = r_ifValid;
  assign lsValid_o = r_lsValid;
  assign ifData_o  = r_ifData;
  assign lsData_o  = r_lsData;
  assign romReq_o  = (r_state == ACCESS);
  assign romAddr_o = r_addr;

endmodule

// File: tb/tb_rom_fetch_arbiter.sv
// Randomized scoreboard bench for rom_fetch_arbiter: two requester drivers, a ROM model,
// and a monitor holding a transaction-level model of the arbiter.
module tb_rom_fetch_arbiter;

  localparam int WS = 2;
`ifdef ROM_ALIGN_CHK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ifReq_i = 1'b0;
  logic [31:0] ifAddr_i = '0;
  logic        lsReq_i = 1'b0;
  logic [31:0] lsAddr_i = '0;
  logic [31:0] romInst_i = '0;
  logic        romOk_i = 1'b0;
  logic        ifAck_o, ifValid_o, ifErr_o;
  logic        lsAck_o, lsValid_o, lsErr_o;
  logic [31:0] ifData_o, lsData_o;
  logic        romReq_o;
  logic [31:0] romAddr_o;

  rom_fetch_arbiter #(.WAIT_STATES(WS), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .ifReq_i(ifReq_i), .ifAddr_i(ifAddr_i), .ifAck_o(ifAck_o),
    .ifData_o(ifData_o), .ifValid_o(ifValid_o), .ifErr_o(ifErr_o),
    .lsReq_i(lsReq_i), .lsAddr_i(lsAddr_i), .lsAck_o(lsAck_o),
    .lsData_o(lsData_o), .lsValid_o(lsValid_o), .lsErr_o(lsErr_o),
    .romReq_o(romReq_o), .romAddr_o(romAddr_o),
    .romInst_i(romInst_i), .romOk_i(romOk_i)
  );

  always #5 clk = ~clk;

  int checkCount = 0;
  int passCount  = 0;
  int cyc        = 0;
  int reqPct     = 60;
  int okPct      = 70;
  bit stimOn     = 1'b0;

  // Transaction-level model: at most one access outstanding, tie goes to the port not served last.
  bit          mBusy, mOwnerLs, mErrAcc, mLastLs;
  logic [31:0] mAddr;
  int          mAckCycle;
  bit          expAckIf, expAckLs, expValidIf, expValidLs;
  logic [31:0] lastIfData, lastLsData;
  logic [32:0] qIf[$];
  logic [32:0] qLs[$];

  function automatic logic [31:0] romWord(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h0BADF00D;
  endfunction

  function automatic logic isMisaligned(input logic [31:0] a);
    return ALIGN_CHK && (a[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] randAddr();
    logic [31:0] a;
    a = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
    if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
    return a;
  endfunction

  function automatic logic [127:0] allOut();
    return {25'h0, ifAck_o, ifValid_o, ifErr_o, lsAck_o, lsValid_o, lsErr_o,
            romReq_o, ifData_o, lsData_o, romAddr_o};
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic resetModel();
    mBusy = 0; mOwnerLs = 0; mErrAcc = 0; mLastLs = 1'b1;
    mAddr = '0; mAckCycle = 0;
    expAckIf = 0; expAckLs = 0; expValidIf = 0; expValidLs = 0;
    lastIfData = '0; lastLsData = '0;
    qIf.delete(); qLs.delete();
  endtask

  // Requester protocol: hold req/addr until Ack, then drop or present the next address.
  task automatic applyStimulus(input logic ackSeen, input logic curReq, input logic [31:0] curAddr,
                               output logic nextReq, output logic [31:0] nextAddr);
    nextReq  = curReq;
    nextAddr = curAddr;
    if (!(curReq && !ackSeen)) begin
      if (stimOn && (int'($urandom_range(0, 99)) < reqPct)) begin
        nextReq  = 1'b1;
        nextAddr = randAddr();
      end else begin
        nextReq = 1'b0;
      end
    end
  endtask

  task automatic runCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin : ifDriver
    logic        nReq;
    logic [31:0] nAddr;
    forever begin
      @(negedge clk);
      applyStimulus(ifAck_o, ifReq_i, ifAddr_i, nReq, nAddr);
      ifReq_i  = nReq;
      ifAddr_i = nAddr;
    end
  end

  initial begin : lsDriver
    logic        nReq;
    logic [31:0] nAddr;
    forever begin
      @(negedge clk);
      applyStimulus(lsAck_o, lsReq_i, lsAddr_i, nReq, nAddr);
      lsReq_i  = nReq;
      lsAddr_i = nAddr;
    end
  end

  initial begin : romModel
    forever begin
      @(negedge clk);
      romInst_i = romWord(romAddr_o);
      romOk_i   = (int'($urandom_range(0, 99)) < okPct);
    end
  end

  initial begin : monitor
    logic        winLs;
    logic [31:0] a;
    logic [32:0] e;
    resetModel();
    forever begin
      @(negedge clk);
      #2;
      cyc++;
      if (!reset_n) begin
        resetModel();
      end else begin
        if (expAckIf || expAckLs || ifAck_o || lsAck_o)
          checkOutput("ack", {126'h0, ifAck_o, lsAck_o}, {126'h0, expAckIf, expAckLs});
        if (expValidIf || expValidLs || ifValid_o || lsValid_o)
          checkOutput("valid", {126'h0, ifValid_o, lsValid_o}, {126'h0, expValidIf, expValidLs});
        expAckIf = 0; expAckLs = 0; expValidIf = 0; expValidLs = 0;

        if (ifValid_o) begin
          checkOutput("ifPending", qIf.size(), 1);
          if (qIf.size() > 0) begin
            e = qIf.pop_front();
            checkOutput("ifData", ifData_o, e[31:0]);
            checkOutput("ifErr", ifErr_o, e[32]);
            lastIfData = e[31:0];
          end
        end else begin
          checkOutput("ifDataHold", ifData_o, lastIfData);
        end
        if (lsValid_o) begin
          checkOutput("lsPending", qLs.size(), 1);
          if (qLs.size() > 0) begin
            e = qLs.pop_front();
            checkOutput("lsData", lsData_o, e[31:0]);
            checkOutput("lsErr", lsErr_o, e[32]);
            lastLsData = e[31:0];
          end
        end else begin
          checkOutput("lsDataHold", lsData_o, lastLsData);
        end

        checkOutput("romReq", romReq_o, mBusy && !mErrAcc);
        if (mBusy && !mErrAcc) checkOutput("romAddr", romAddr_o, mAddr);

        if (mBusy) begin
          if (mErrAcc ? (cyc == mAckCycle) : ((cyc >= mAckCycle + WS) && romOk_i)) begin
            if (mOwnerLs) expValidLs = 1; else expValidIf = 1;
            mLastLs = mOwnerLs;
            mBusy   = 0;
          end
        end else if (ifReq_i || lsReq_i) begin
          winLs = lsReq_i && (!ifReq_i || !mLastLs);
          a     = winLs ? lsAddr_i : ifAddr_i;
          mErrAcc   = isMisaligned(a);
          e         = mErrAcc ? {1'b1, 32'h0} : {1'b0, romWord(a)};
          if (winLs) begin qLs.push_back(e); expAckLs = 1; end
          else begin qIf.push_back(e); expAckIf = 1; end
          mBusy     = 1;
          mOwnerLs  = winLs;
          mAddr     = a;
          mAckCycle = cyc + 1;
        end
      end
    end
  end

  initial begin : mainSeq
    bit found;
    bit drained;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("resetState", allOut(), '0);
    #1 reset_n = 1'b1;

    stimOn = 1; reqPct = 60;  okPct = 70;  runCycles(600);
    reqPct = 100; okPct = 100; runCycles(200);
    reqPct = 50;  okPct = 10;  runCycles(400);

    reqPct = 80; okPct = 20;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      #3;
      if (mBusy && !mErrAcc && (cyc >= mAckCycle)) found = 1;
    end
    checkOutput("reachAccess", found, 1);
    if (found) begin
      reset_n = 1'b0;
      #1 checkOutput("asyncReset", allOut(), '0);
      repeat (2) @(negedge clk);
      #1 reset_n = 1'b1;
    end

    reqPct = 60; okPct = 70; runCycles(300);

    stimOn = 0;
    drained = 0;
    for (int i = 0; i < 300 && !drained; i++) begin
      @(negedge clk);
      #3;
      if (!mBusy && !ifReq_i && !lsReq_i && (qIf.size() == 0) && (qLs.size() == 0)) drained = 1;
    end
    checkOutput("drain", drained, 1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
